// File: rtl/periph_bus_controller_pkg.sv
// Shared types and constants for the peripheral bus controller.
// Imported by the interface, the decoder and the top.
package periph_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERROR
  } state_t;

  localparam int SEL_W = 4;
  localparam int REG_W = 4;
  localparam int MAX_PERIPH = 16;
  localparam logic [31:0] ERR_WORD = 32'h0;

endpackage

// File: rtl/periph_bus_controller_if.sv
// Core-side and peripheral-side bus bundle of the controller.
// master = controller view, slave = core/peripheral environment view.
interface periph_bus_controller_if
  import periph_pkg::*;
#(
  parameter int N_PERIPH = 3,
  parameter int DATA_W = 32
);

  logic [31:0] address;
  logic rw;
  logic ce;
  logic [DATA_W-1:0] data_from_mips;
  logic [DATA_W-1:0] data_to_mips;
  logic stall;
  logic bus_error;
  logic [N_PERIPH-1:0] ce_out;
  logic [N_PERIPH-1:0] rw_out;
  logic [REG_W-1:0] address_reg;
  logic [DATA_W-1:0] data_to_periph;
  logic [N_PERIPH*DATA_W-1:0] data_from_periph;
  logic [N_PERIPH-1:0] periph_ready;

  modport master (
    input  address, rw, ce, data_from_mips,
    input  data_from_periph, periph_ready,
    output data_to_mips, stall, bus_error,
    output ce_out, rw_out, address_reg, data_to_periph
  );

  modport slave (
    output address, rw, ce, data_from_mips,
    output data_from_periph, periph_ready,
    input  data_to_mips, stall, bus_error,
    input  ce_out, rw_out, address_reg, data_to_periph
  );

endinterface

// File: rtl/periph_bus_controller_addr_decoder.sv
// Selector to one-hot peripheral enable; valid is low for
// selectors with no attached peripheral.
module periph_addr_decoder
  import periph_pkg::*;
#(
  parameter int N_PERIPH = 3
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [N_PERIPH-1:0] onehot,
  output logic                valid
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_PERIPH; i++)
      onehot[i] = (sel == SEL_W'(i));
    valid = |onehot;
  end

endmodule

// File: rtl/periph_bus_controller.sv
// MIPS data port to peripheral bus controller with bus-error termination.
// Define PERIPH_TIMEOUT_EN to abort accesses whose peripheral never answers.
module periph_bus_controller
  import periph_pkg::*;
#(
  parameter int N_PERIPH = 3,
  parameter int DATA_W = 32,
  parameter int SEL_LSB = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clock,
  input logic reset_n,
  periph_bus_controller_if.master bus
);

  state_t state, state_nx;

  logic req;
  logic [SEL_W-1:0] sel;
  logic [N_PERIPH-1:0] sel_oh;
  logic sel_ok;

  logic [N_PERIPH-1:0] ce_q;
  logic rw_q;
  logic [REG_W-1:0] reg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic ready_hit;
  logic expire;
  logic [DATA_W-1:0] rd_mux;
  logic stall_c;
  logic err_c;
  logic [DATA_W-1:0] dout_c;
  logic unused;

  assign req = bus.ce && bus.address[31];
  assign sel = bus.address[SEL_LSB+SEL_W-1:SEL_LSB];
  assign unused = ^bus.address;

  periph_addr_decoder #(
    .N_PERIPH(N_PERIPH)
  ) u_dec (
    .sel(sel),
    .onehot(sel_oh),
    .valid(sel_ok)
  );

  // ce_q doubles as the latched selector mask
  assign ready_hit = |(bus.periph_ready & ce_q);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_PERIPH; i++)
      if (ce_q[i])
        rd_mux = rd_mux | bus.data_from_periph[i*DATA_W +: DATA_W];
  end

`ifdef PERIPH_TIMEOUT_EN
  logic [7:0] cnt;

  assign expire = !ready_hit &&
    (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (state == IDLE)
      cnt <= '0;
    else if (state == ACCESS && !ready_hit)
      cnt <= cnt + 8'd1;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall_c = 1'b0;
    err_c = 1'b0;
    dout_c = DATA_W'(ERR_WORD);
    case (state)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          state_nx = sel_ok ? ACCESS : ERROR;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (ready_hit)
          state_nx = DONE;
        else if (expire)
          state_nx = ERROR;
      end
      DONE: begin
        if (!rw_q)
          dout_c = rdata_q;
        state_nx = IDLE;
      end
      ERROR: begin
        err_c = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ce_q <= '0;
      rw_q <= 1'b0;
      reg_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state == IDLE) begin
      if (req && sel_ok) begin
        ce_q <= sel_oh;
        rw_q <= bus.rw;
        reg_q <= bus.address[SEL_LSB-1:SEL_LSB-REG_W];
        wdata_q <= bus.data_from_mips;
      end
    end else if (state == ACCESS) begin
      if (ready_hit) begin
        ce_q <= '0;
        if (!rw_q)
          rdata_q <= rd_mux;
      end else if (expire) begin
        ce_q <= '0;
      end
    end
  end

  assign bus.stall = stall_c;
  assign bus.bus_error = err_c;
  assign bus.data_to_mips = dout_c;
  assign bus.ce_out = ce_q;
  assign bus.rw_out = ce_q & {N_PERIPH{rw_q}};
  assign bus.address_reg = reg_q;
  assign bus.data_to_periph = wdata_q;

endmodule

// File: tb/tb_periph_bus_controller.sv
// Self-checking bench for periph_bus_controller: vector table,
// scoreboard of expected completions, reset-mid-access sequence.
module tb_periph_bus_controller;

  logic clock;
  logic reset_n;

  periph_bus_controller_if #(
    .N_PERIPH(3),
    .DATA_W(32)
  ) bus ();

  periph_bus_controller #(
    .N_PERIPH(3),
    .DATA_W(32),
    .SEL_LSB(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rslice;
    int          exp_stall;
    logic [2:0]  exp_ce;
    int          exp_ce_cyc;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [3:0]  exp_reg;
  } vec_t;

  vec_t vecs[8];
  int n_vec;
  vec_t sb[$];

  int n_pass = 0;
  int n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_access(input vec_t v);
    int stall_cnt;
    int ce_cyc;
    int acc;
    bit done;
    bit first;
    logic [2:0] ce_seen;
    logic [2:0] noise;
    int s;
    vec_t e;
    s = int'(v.addr[11:8]);
    noise = 3'b000;
    for (int i = 0; i < 3; i++)
      if (i != s) noise[i] = 1'b1;
    @(posedge clock);
    #1;
    bus.address = v.addr;
    bus.rw = v.rw;
    bus.ce = 1'b1;
    bus.data_from_mips = v.wdata;
    bus.data_from_periph = {32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
    bus.periph_ready = noise;
    sb.push_back(v);
    stall_cnt = 0;
    ce_cyc = 0;
    acc = 0;
    done = 0;
    first = 1;
    ce_seen = '0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clock);
      if (bus.ce_out != 3'b000) begin
        ce_cyc++;
        acc++;
        ce_seen = ce_seen | bus.ce_out;
        if (first) begin
          first = 0;
          chk("data_to_periph", bus.data_to_periph, v.wdata);
          chk("address_reg", 32'(bus.address_reg), 32'(v.exp_reg));
          chk("rw_out", 32'(bus.rw_out),
              32'(v.rw ? v.exp_ce : 3'b000));
        end
        if (acc == v.delay && s < 3) begin
          bus.periph_ready[s] = 1'b1;
          bus.data_from_periph[s*32 +: 32] = v.rslice;
        end
      end
      if (bus.stall)
        stall_cnt++;
      else begin
        done = 1;
        e = sb.pop_front();
        chk("stall_cycles", 32'(stall_cnt), 32'(e.exp_stall));
        chk("bus_error", 32'(bus.bus_error), 32'(e.exp_err));
        chk("data_to_mips", bus.data_to_mips, e.exp_data);
        chk("ce_seen", 32'(ce_seen), 32'(e.exp_ce));
        chk("ce_cycles", 32'(ce_cyc), 32'(e.exp_ce_cyc));
        chk("ce_out_end", 32'(bus.ce_out), 32'd0);
      end
    end
    if (!done)
      chk("access_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    bus.ce = 1'b0;
    bus.periph_ready = '0;
    @(negedge clock);
    chk("idle_stall", 32'(bus.stall), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0210, 1'b1, 32'h1234_5678, 1, 32'h0,
                2, 3'b100, 1, 1'b0, 32'h0, 4'h1};
    vecs[1] = '{32'h8000_0030, 1'b0, 32'h0, 4, 32'hCAFE_F00D,
                5, 3'b001, 4, 1'b0, 32'hCAFE_F00D, 4'h3};
    vecs[2] = '{32'h8000_0500, 1'b0, 32'h0, 1, 32'h0,
                1, 3'b000, 0, 1'b1, 32'h0, 4'h0};
    vecs[3] = '{32'h0000_0100, 1'b0, 32'h0, 1, 32'h0,
                0, 3'b000, 0, 1'b0, 32'h0, 4'h0};
    vecs[4] = '{32'h8000_0140, 1'b0, 32'h0, 2, 32'hA5A5_0001,
                3, 3'b010, 2, 1'b0, 32'hA5A5_0001, 4'h4};
    vecs[5] = '{32'h8000_01F0, 1'b1, 32'hDEAD_BEEF, 3, 32'h7777_7777,
                4, 3'b010, 3, 1'b0, 32'h0, 4'hF};
    vecs[6] = '{32'h8000_0F00, 1'b1, 32'h1111_2222, 1, 32'h0,
                1, 3'b000, 0, 1'b1, 32'h0, 4'h0};
    n_vec = 7;
`ifdef PERIPH_TIMEOUT_EN
    vecs[7] = '{32'h8000_0100, 1'b0, 32'h0, 0, 32'h0,
                9, 3'b010, 8, 1'b1, 32'h0, 4'h0};
    n_vec = 8;
`endif

    reset_n = 1'b0;
    bus.address = '0;
    bus.rw = 1'b0;
    bus.ce = 1'b0;
    bus.data_from_mips = '0;
    bus.data_from_periph = '0;
    bus.periph_ready = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ce_out", 32'(bus.ce_out), 32'd0);
    chk("rst_rw_out", 32'(bus.rw_out), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_bus_error", 32'(bus.bus_error), 32'd0);
    chk("rst_data_to_mips", bus.data_to_mips, 32'd0);
    chk("rst_address_reg", 32'(bus.address_reg), 32'd0);
    chk("rst_data_to_periph", bus.data_to_periph, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < n_vec; i++)
      do_access(vecs[i]);

    // reset in the middle of a write that never completes
    @(posedge clock);
    #1;
    bus.address = 32'h8000_0210;
    bus.rw = 1'b1;
    bus.ce = 1'b1;
    bus.data_from_mips = 32'h55AA_55AA;
    bus.periph_ready = 3'b000;
    @(negedge clock);
    @(negedge clock);
    chk("mid_ce_out", 32'(bus.ce_out), 32'h4);
    chk("mid_data_to_periph", bus.data_to_periph, 32'h55AA_55AA);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_ce_out", 32'(bus.ce_out), 32'd0);
    chk("arst_rw_out", 32'(bus.rw_out), 32'd0);
    chk("arst_data_to_periph", bus.data_to_periph, 32'd0);
    chk("arst_address_reg", 32'(bus.address_reg), 32'd0);
    chk("arst_bus_error", 32'(bus.bus_error), 32'd0);
    chk("arst_data_to_mips", bus.data_to_mips, 32'd0);
    chk("arst_stall_req", 32'(bus.stall), 32'd1);
    bus.ce = 1'b0;
    #1;
    chk("arst_stall_noreq", 32'(bus.stall), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    do_access(vecs[0]);
    do_access(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
